pong_game_sequencer: RTL
========================

# pong_game_sequencer

Game-flow controller for the single-paddle VGA Pong core. It consumes the per-frame tick from the VGA timing counters and event pulses from the ball/paddle physics. It then decides when the ball may advance, when it is recentred, whether the paddle may move, and how fast play runs. It also keeps score and lives, so the physics block becomes a pure datapath gated by this sequencer.

## Interface
Parameters:
- `LIVES`, 3: lives loaded at game start (1..3; fits the 2-bit `lives` port).
- `SERVE_FRAMES`, 60: frames held in SERVE before the ball launches (1..255).
- `SPEED_DIV_INIT`, 2: frames per ball step at rally start (1..7).
- `RALLY_STEP`, 4: paddle hits per speed increase (1..15; used only with the ramp macro).

Ports:
- `clk`  in  1  pixel clock, 25 MHz.
- `rst_n`  in  1  reset; asynchronous assert, active-low.
- `frame_tick`  in  1  one-cycle pulse when h_count==0 and v_count==0.
- `btn_start`  in  1  start button, level, already synchronous to `clk`.
- `ball_miss`  in  1  one-cycle pulse from physics: ball passed the left wall.
- `paddle_hit`  in  1  one-cycle pulse from physics: ball reflected off the paddle.
- `ball_step`  out  1  one-cycle pulse; physics advances the ball once.
- `ball_reset`  out  1  one-cycle pulse; physics recentres the ball and restores its default velocity.
- `paddle_en`  out  1  level; paddle movement permitted.
- `state`  out  2  0=IDLE, 1=SERVE, 2=PLAY, 3=OVER.
- `lives`  out  2  remaining lives.
- `score`  out  8  total paddle hits this game, saturating at 255.
- `speed_div`  out  3  current frames-per-step divider (1..7).

## Operation
- **Start detect.**
  - `btn_start` is sampled only on `frame_tick` into `start_q`.
  - A start event is `frame_tick & btn_start & ~start_q`: a press edge seen at frame granularity.
- **IDLE.**
  - `paddle_en`=0; no `ball_step`.
  - On a start event: go to SERVE, `lives`←LIVES, `score`←0, pulse `ball_reset`.
- **SERVE.**
  - `paddle_en`=1; no `ball_step`.
  - `serve_cnt` increments on each `frame_tick`.
  - When `serve_cnt` reaches SERVE_FRAMES-1 on a `frame_tick`: go to PLAY and clear `serve_cnt`.
  - Entering SERVE from any state clears `serve_cnt`, `div_cnt` and `rally_cnt`, and sets `speed_div`←SPEED_DIV_INIT.
- **PLAY.**
  - `paddle_en`=1.
  - `div_cnt` counts `frame_tick`s. When `div_cnt`==`speed_div`-1 on a `frame_tick`, pulse `ball_step` and clear `div_cnt`.
  - `paddle_hit`: `score`+1 (saturating at 255) and `rally_cnt`+1 (4-bit, wraps).
  - `ball_miss` with `lives`>1: `lives`-1, go to SERVE, pulse `ball_reset`.
  - `ball_miss` with `lives`==1: `lives`←0, go to OVER. No `ball_reset`; the ball stays frozen.
- **OVER.**
  - `paddle_en`=0; `score` held for display.
  - A start event behaves exactly as in IDLE.
- **Priorities and boundaries.**
  - `ball_miss` and `paddle_hit` in the same cycle: the miss wins and the hit is dropped.
  - `ball_miss` and a `frame_tick` that would step the ball: the miss wins and no `ball_step` is issued.
  - `ball_miss`/`paddle_hit` outside PLAY are ignored.
  - `btn_start` held through game over does not restart play; a new press edge is required.
  - A `speed_div` change mid-count: `div_cnt` is compared against the new value; if `div_cnt` ≥ new `speed_div`-1, step on the next `frame_tick`.

## Timing
- All outputs are registered. Decisions are made on the cycle carrying `frame_tick` or the event pulse.
- State, counters and output pulses update on the next rising edge, i.e. 1-cycle latency.
- `ball_step` and `ball_reset` are high for exactly one `clk` cycle. At most one `ball_step` per frame.
- Reset values (asynchronous on `rst_n` low):
  - `state`=IDLE, `ball_step`=0, `ball_reset`=0, `paddle_en`=0.
  - `lives`=LIVES, `score`=0, `speed_div`=SPEED_DIV_INIT.
  - `start_q`=0 and all internal counters 0.
- Reset asserted mid-game returns to IDLE immediately; no pulse is emitted during or on the release edge.

## Configuration
- `PONG_SPEED_RAMP_EN` defined:
  - Each `paddle_hit` that brings `rally_cnt` to a multiple of RALLY_STEP decrements `speed_div`, floored at 1.
  - The ramp restarts at each SERVE entry.
- Not defined: `speed_div` is constant at SPEED_DIV_INIT; `rally_cnt` logic is removed.

## Test plan
- Reset, then `btn_start` rising before a `frame_tick` -> cycle after the tick: `state`=1, `ball_reset` 1-cycle pulse, `lives`=3, `score`=0, `paddle_en`=1.
- SERVE_FRAMES=60 -> `state`=2 one cycle after the 60th `frame_tick`. With `speed_div`=2, `ball_step` follows on every second subsequent tick.
- Three `ball_miss` pulses in PLAY -> `lives` goes 2 and 1 with SERVE re-entry and `ball_reset` each time. The third miss gives `state`=3, `lives`=0, no `ball_reset`, `paddle_en`=0.
- `ball_miss` and `paddle_hit` in the same cycle -> `score` unchanged, `lives` decremented. A `frame_tick` coinciding with the miss produces no `ball_step`.
- With `PONG_SPEED_RAMP_EN`, RALLY_STEP=4, SPEED_DIV_INIT=2 -> after 4 hits `speed_div`=1 and stays 1 after 8. After a miss it returns to 2. Without the macro it stays 2.
- `btn_start` held high from OVER -> no restart. Release, then press -> SERVE with `score`=0. Repeated hits saturate `score` at 255.

Source files
------------

// File: rtl/pong_game_sequencer.sv
// rtl/pong_game_sequencer.sv - Pong game-flow FSM: serve/play/over sequencing, score, lives, ball pacing
// Optional speed ramp enabled by defining PONG_SPEED_RAMP_EN.
module pong_game_sequencer #(
    parameter int LIVES          = 3,
    parameter int SERVE_FRAMES   = 60,
    parameter int SPEED_DIV_INIT = 2,
    parameter int RALLY_STEP     = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       btn_start,
    input  logic       ball_miss,
    input  logic       paddle_hit,
    output logic       ball_step,
    output logic       ball_reset,
    output logic       paddle_en,
    output logic [1:0] state,
    output logic [1:0] lives,
    output logic [7:0] score,
    output logic [2:0] speed_div
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    if (LIVES < 1 || LIVES > 3 || SERVE_FRAMES < 1 || SERVE_FRAMES > 255 ||
        SPEED_DIV_INIT < 1 || SPEED_DIV_INIT > 7 || RALLY_STEP < 1 || RALLY_STEP > 15) begin : g_bad_param
        $error("pong_game_sequencer: parameter out of range");
    end

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);
    localparam logic [7:0] SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [2:0] DIV_INIT   = 3'(SPEED_DIV_INIT);

    state_t     st;
    logic       start_q;
    logic [7:0] serve_cnt;
    logic [2:0] div_cnt;
    logic       start_ev;
    logic       div_done;
    logic       enter_serve;

    // Press edge observed at frame granularity only, so bounce within a frame is invisible.
    assign start_ev = frame_tick & btn_start & ~start_q;
    // >= rather than == so a divider that shrinks below the running count still steps next tick.
    assign div_done = (div_cnt >= (speed_div - 3'd1));
    assign enter_serve = (((st == ST_IDLE) || (st == ST_OVER)) && start_ev) ||
                         ((st == ST_PLAY) && ball_miss && (lives > 2'd1));
    assign state = st;

`ifdef PONG_SPEED_RAMP_EN
    logic [3:0] rally_cnt;
    logic [3:0] rally_next;
    logic       ramp_hit;

    assign rally_next = rally_cnt + 4'd1;
    assign ramp_hit   = ((rally_next % 4'(RALLY_STEP)) == 4'd0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st         <= ST_IDLE;
            start_q    <= 1'b0;
            serve_cnt  <= 8'd0;
            div_cnt    <= 3'd0;
            ball_step  <= 1'b0;
            ball_reset <= 1'b0;
            paddle_en  <= 1'b0;
            lives      <= LIVES_INIT;
            score      <= 8'd0;
            speed_div  <= DIV_INIT;
`ifdef PONG_SPEED_RAMP_EN
            rally_cnt  <= 4'd0;
`endif
        end else begin
            ball_step  <= 1'b0;
            ball_reset <= 1'b0;
            if (frame_tick) begin
                start_q <= btn_start;
            end

            case (st)
                ST_IDLE, ST_OVER: begin
                    if (start_ev) begin
                        st         <= ST_SERVE;
                        lives      <= LIVES_INIT;
                        score      <= 8'd0;
                        ball_reset <= 1'b1;
                        paddle_en  <= 1'b1;
                    end
                end

                ST_SERVE: begin
                    if (frame_tick) begin
                        if (serve_cnt == SERVE_LAST) begin
                            st        <= ST_PLAY;
                            serve_cnt <= 8'd0;
                        end else begin
                            serve_cnt <= serve_cnt + 8'd1;
                        end
                    end
                end

                ST_PLAY: begin
                    // A miss pre-empts both a coincident hit and a coincident step.
                    if (ball_miss) begin
                        if (lives > 2'd1) begin
                            lives      <= lives - 2'd1;
                            st         <= ST_SERVE;
                            ball_reset <= 1'b1;
                        end else begin
                            lives     <= 2'd0;
                            st        <= ST_OVER;
                            paddle_en <= 1'b0;
                        end
                    end else begin
                        if (paddle_hit) begin
                            if (score != 8'hFF) begin
                                score <= score + 8'd1;
                            end
`ifdef PONG_SPEED_RAMP_EN
                            rally_cnt <= rally_next;
                            if (ramp_hit && (speed_div > 3'd1)) begin
                                speed_div <= speed_div - 3'd1;
                            end
`endif
                        end
                        if (frame_tick) begin
                            if (div_done) begin
                                ball_step <= 1'b1;
                                div_cnt   <= 3'd0;
                            end else begin
                                div_cnt <= div_cnt + 3'd1;
                            end
                        end
                    end
                end

                default: st <= ST_IDLE;
            endcase

            if (enter_serve) begin
                serve_cnt <= 8'd0;
                div_cnt   <= 3'd0;
                speed_div <= DIV_INIT;
`ifdef PONG_SPEED_RAMP_EN
                rally_cnt <= 4'd0;
`endif
            end
        end
    end

endmodule
